// File: rtl/decode_sequencer.sv
// decode_sequencer: owns the shared bitstream shifter and hands it between
// the header decoder, the slice decoder and its own start-code scan.
// Tracks picture/sequence ends, counts pictures and aborts hung sub-decoders.
module decode_sequencer #(
  parameter logic [19:0] WATCHDOG_CYCLES = 20'hFFFFF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_Decode_I,
  input  logic        Stop_Decode_I,
  input  logic [31:0] Data_In_I,
  input  logic        Byte_Allign_I,
  input  logic        Shift_Busy_I,
  output logic        Start_Header_Decode_O,
  input  logic        Done_Header_Decode_I,
  input  logic        Hdr_Shift_1_En_I,
  input  logic        Hdr_Shift_8_En_I,
  output logic        Slice_Start_O,
  input  logic        Slice_Done_I,
  input  logic        Slc_Shift_1_En_I,
  input  logic        Slc_Shift_8_En_I,
  output logic        Shift_1_En_O,
  output logic        Shift_8_En_O,
  output logic        Picture_Done_O,
  output logic [15:0] Picture_Count_O,
  output logic        Seq_End_O,
  output logic        Error_O
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_START,
    HDR_WAIT,
    SLICE_START,
    SLICE_WAIT,
    SCAN,
    PIC_END
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HDR,
    OWN_SLC
  } owner_t;

  state_t      state;
  state_t      next_state;
  owner_t      owner;
  owner_t      next_owner;
  logic        guard;
  logic [19:0] wd_cnt;
  logic        in_wait;
  logic        wd_expired;

  logic        is_start_code;
  logic        is_slice_code;
  logic        is_seq_end;

  logic        start_hdr;
  logic        fire_slice;
  logic        fire_pic;
  logic        set_seq_end;
  logic        set_error;
  logic        clear_sticky;

  logic        slice_start_q;
  logic        pic_done_q;
  logic [15:0] pic_count;
  logic        seq_end_q;
  logic        error_q;

  assign is_start_code = (Data_In_I[31:8] == 24'h000001);
  assign is_slice_code = is_start_code &&
                         (Data_In_I[7:0] >= 8'h01) &&
                         (Data_In_I[7:0] <= 8'hAF);
  assign is_seq_end    = (Data_In_I == 32'h000001B7);

  assign in_wait    = (state == HDR_WAIT) || (state == SLICE_WAIT);
  assign wd_expired = ((wd_cnt + 20'd1) == WATCHDOG_CYCLES);

  // Next-state, next-owner and one-cycle event decode; Stop overrides everything
  always_comb begin
    next_state   = state;
    next_owner   = owner;
    start_hdr    = 1'b0;
    fire_slice   = 1'b0;
    fire_pic     = 1'b0;
    set_seq_end  = 1'b0;
    set_error    = 1'b0;
    clear_sticky = 1'b0;
    if (Stop_Decode_I) begin
      next_state = IDLE;
      next_owner = OWN_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (Start_Decode_I) begin
            clear_sticky = 1'b1;
            next_state   = HDR_START;
          end
        end
        HDR_START: begin
          start_hdr  = 1'b1;
          next_owner = OWN_HDR;
          next_state = HDR_WAIT;
        end
        HDR_WAIT: begin
          if (guard && Done_Header_Decode_I) begin
            next_owner = OWN_NONE;
            next_state = SLICE_START;
          end else if (wd_expired) begin
            set_error  = 1'b1;
            next_owner = OWN_NONE;
            next_state = IDLE;
          end
        end
        SLICE_START: begin
          if (is_slice_code) begin
            fire_slice = 1'b1;
            next_owner = OWN_SLC;
            next_state = SLICE_WAIT;
          end else begin
            next_state = SCAN;
          end
        end
        SLICE_WAIT: begin
          if (Slice_Done_I) begin
            next_owner = OWN_NONE;
            next_state = SCAN;
          end else if (wd_expired) begin
            set_error  = 1'b1;
            next_owner = OWN_NONE;
            next_state = IDLE;
          end
        end
        SCAN: begin
          if (is_slice_code) begin
            next_state = SLICE_START;
          end else if (is_start_code) begin
            fire_pic   = 1'b1;
            next_state = PIC_END;
          end
        end
        PIC_END: begin
          if (is_seq_end) begin
            set_seq_end = 1'b1;
            next_state  = IDLE;
          end else begin
            next_state = HDR_START;
          end
        end
        default: begin
          next_state = IDLE;
          next_owner = OWN_NONE;
        end
      endcase
    end
  end

  // Shifter mux: the registered owner passes its requests; with no owner only SCAN shifts
  always_comb begin
    Shift_1_En_O = 1'b0;
    Shift_8_En_O = 1'b0;
    case (owner)
      OWN_HDR: begin
        Shift_1_En_O = Hdr_Shift_1_En_I;
        Shift_8_En_O = Hdr_Shift_8_En_I;
      end
      OWN_SLC: begin
        Shift_1_En_O = Slc_Shift_1_En_I;
        Shift_8_En_O = Slc_Shift_8_En_I;
      end
      default: begin
        if ((state == SCAN) && !Stop_Decode_I && !is_start_code && !Shift_Busy_I) begin
          if (Byte_Allign_I) begin
            Shift_8_En_O = 1'b1;
          end else begin
            Shift_1_En_O = 1'b1;
          end
        end
      end
    endcase
  end

  // State and shifter-owner registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= next_state;
      owner <= next_owner;
    end
  end

  // Guard masks a stale header Done during the first HDR_WAIT cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      guard <= 1'b0;
    end else begin
      guard <= (state == HDR_WAIT) && (next_state == HDR_WAIT);
    end
  end

  // Watchdog counts cycles spent in either wait state, zero elsewhere
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= 20'd0;
    end else if (in_wait) begin
      wd_cnt <= wd_cnt + 20'd1;
    end else begin
      wd_cnt <= 20'd0;
    end
  end

  // Registered slice-start and picture-done pulses plus the picture counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slice_start_q <= 1'b0;
      pic_done_q    <= 1'b0;
      pic_count     <= 16'd0;
    end else begin
      slice_start_q <= fire_slice;
      pic_done_q    <= fire_pic;
      if (fire_pic) begin
        pic_count <= pic_count + 16'd1;
      end
    end
  end

  // Sticky sequence-end and error flags, cleared when a new decode starts
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seq_end_q <= 1'b0;
      error_q   <= 1'b0;
    end else if (clear_sticky) begin
      seq_end_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (set_seq_end) begin
        seq_end_q <= 1'b1;
      end
      if (set_error) begin
        error_q <= 1'b1;
      end
    end
  end

  assign Start_Header_Decode_O = start_hdr;
  assign Slice_Start_O         = slice_start_q;
  assign Picture_Done_O        = pic_done_q;
  assign Picture_Count_O       = pic_count;
  assign Seq_End_O             = seq_end_q;
  assign Error_O               = error_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed vectors with hand-computed expectations
// for decode_sequencer, run with a 16-cycle watchdog.
module tb_decode_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        Start_Decode_I;
  logic        Stop_Decode_I;
  logic [31:0] Data_In_I;
  logic        Byte_Allign_I;
  logic        Shift_Busy_I;
  logic        Start_Header_Decode_O;
  logic        Done_Header_Decode_I;
  logic        Hdr_Shift_1_En_I;
  logic        Hdr_Shift_8_En_I;
  logic        Slice_Start_O;
  logic        Slice_Done_I;
  logic        Slc_Shift_1_En_I;
  logic        Slc_Shift_8_En_I;
  logic        Shift_1_En_O;
  logic        Shift_8_En_O;
  logic        Picture_Done_O;
  logic [15:0] Picture_Count_O;
  logic        Seq_End_O;
  logic        Error_O;

  int assertCount = 0;
  int failCount   = 0;

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  decode_sequencer #(.WATCHDOG_CYCLES(20'd16)) dut (
    .clock                 (clock),
    .resetn                (resetn),
    .Start_Decode_I        (Start_Decode_I),
    .Stop_Decode_I         (Stop_Decode_I),
    .Data_In_I             (Data_In_I),
    .Byte_Allign_I         (Byte_Allign_I),
    .Shift_Busy_I          (Shift_Busy_I),
    .Start_Header_Decode_O (Start_Header_Decode_O),
    .Done_Header_Decode_I  (Done_Header_Decode_I),
    .Hdr_Shift_1_En_I      (Hdr_Shift_1_En_I),
    .Hdr_Shift_8_En_I      (Hdr_Shift_8_En_I),
    .Slice_Start_O         (Slice_Start_O),
    .Slice_Done_I          (Slice_Done_I),
    .Slc_Shift_1_En_I      (Slc_Shift_1_En_I),
    .Slc_Shift_8_En_I      (Slc_Shift_8_En_I),
    .Shift_1_En_O          (Shift_1_En_O),
    .Shift_8_En_O          (Shift_8_En_O),
    .Picture_Done_O        (Picture_Done_O),
    .Picture_Count_O       (Picture_Count_O),
    .Seq_End_O             (Seq_End_O),
    .Error_O               (Error_O)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic allign, input logic busy);
    Data_In_I     = data;
    Byte_Allign_I = allign;
    Shift_Busy_I  = busy;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  // Walks HDR_START -> HDR_WAIT (two cycles, Done held high) -> SLICE_START,
  // leaving the caller one cycle after SLICE_START.
  task automatic headerFast(input string tag);
    settle();
    checkOutput({tag, "_hdr_pulse"}, Start_Header_Decode_O, 1'b1);
    checkOutput({tag, "_no_pic_done"}, Picture_Done_O, 1'b0);
    nextCycle();
    settle();
    checkOutput({tag, "_w0_no_slice"}, Slice_Start_O, 1'b0);
    nextCycle();
    settle();
    checkOutput({tag, "_w1_no_slice"}, Slice_Start_O, 1'b0);
    nextCycle();
    settle();
    checkOutput({tag, "_ss_no_slice"}, Slice_Start_O, 1'b0);
    nextCycle();
  endtask

  // Bound on total run time
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence
  initial begin
    int s1Count;
    int s8Count;
    int hdrCount;
    int slcCount;
    int errSeen;

    resetn               = 1'b0;
    Start_Decode_I       = 1'b0;
    Stop_Decode_I        = 1'b0;
    Done_Header_Decode_I = 1'b1;
    Hdr_Shift_1_En_I     = 1'b0;
    Hdr_Shift_8_En_I     = 1'b0;
    Slice_Done_I         = 1'b0;
    Slc_Shift_1_En_I     = 1'b0;
    Slc_Shift_8_En_I     = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0);

    repeat (2) nextCycle();
    settle();
    checkOutput("reset_outputs", {Start_Header_Decode_O, Slice_Start_O, Shift_1_En_O, Shift_8_En_O,
                Picture_Done_O, Seq_End_O, Error_O, Picture_Count_O}, 32'h0);
    resetn = 1'b1;
    nextCycle();

    // ---- picture 1: slow header, two slices, picture end ----
    Start_Decode_I = 1'b1;
    settle();
    checkOutput("idle_no_hdr_start", Start_Header_Decode_O, 1'b0);
    nextCycle();
    Start_Decode_I   = 1'b0;
    Hdr_Shift_8_En_I = 1'b1;
    settle();
    checkOutput("hdr_start_pulse", Start_Header_Decode_O, 1'b1);
    checkOutput("hdr8_blocked_hdr_start", Shift_8_En_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("hdr8_pass_w0", Shift_8_En_O, 1'b1);
    checkOutput("hdr_start_single", Start_Header_Decode_O, 1'b0);
    checkOutput("guard_w0", Slice_Start_O, 1'b0);
    s1Count = 0; s8Count = 0; hdrCount = 0; slcCount = 0;
    for (int i = 1; i < 10; i++) begin
      nextCycle();
      Done_Header_Decode_I = 1'b0;
      Hdr_Shift_8_En_I     = (i % 2 == 1);
      Hdr_Shift_1_En_I     = (i % 2 == 0);
      settle();
      s1Count  += int'(Shift_1_En_O);
      s8Count  += int'(Shift_8_En_O);
      hdrCount += int'(Start_Header_Decode_O);
      slcCount += int'(Slice_Start_O);
    end
    checkOutput("hdr8_pass_count", s8Count, 5);
    checkOutput("hdr1_pass_count", s1Count, 4);
    checkOutput("hdr_wait_no_hdr_pulse", hdrCount, 0);
    checkOutput("hdr_wait_no_slice", slcCount, 0);
    nextCycle();
    Done_Header_Decode_I = 1'b1;
    Hdr_Shift_8_En_I     = 1'b0;
    Hdr_Shift_1_En_I     = 1'b0;
    applyStimulus(32'h00000101, 1'b0, 1'b0);
    settle();
    checkOutput("done_cycle_no_slice", Slice_Start_O, 1'b0);
    nextCycle();
    Hdr_Shift_8_En_I = 1'b1;
    settle();
    checkOutput("hdr8_dropped_slice_start", Shift_8_En_O, 1'b0);
    checkOutput("slice1_not_yet", Slice_Start_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("slice1_pulse", Slice_Start_O, 1'b1);
    checkOutput("hdr8_dropped_slc_owner", Shift_8_En_O, 1'b0);
    nextCycle();
    Hdr_Shift_8_En_I = 1'b0;
    Slc_Shift_8_En_I = 1'b1;
    Slice_Done_I     = 1'b1;
    applyStimulus(32'h00000102, 1'b0, 1'b0);
    settle();
    checkOutput("slc8_pass", Shift_8_En_O, 1'b1);
    checkOutput("slice1_single", Slice_Start_O, 1'b0);
    nextCycle();
    Slc_Shift_8_En_I = 1'b0;
    Slice_Done_I     = 1'b0;
    settle();
    checkOutput("scan_no_shift_on_code", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();
    settle();
    checkOutput("slice2_not_yet", Slice_Start_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("slice2_pulse", Slice_Start_O, 1'b1);
    nextCycle();
    Slice_Done_I     = 1'b1;
    Slc_Shift_1_En_I = 1'b1;
    applyStimulus(32'h12345678, 1'b0, 1'b0);
    settle();
    checkOutput("slc1_pass", {Shift_1_En_O, Shift_8_En_O}, 2'b10);
    nextCycle();
    Slice_Done_I     = 1'b0;
    Slc_Shift_1_En_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("scan_shift1_%0d", i), {Shift_1_En_O, Shift_8_En_O}, 2'b10);
      nextCycle();
    end
    applyStimulus(32'h12345678, 1'b1, 1'b1);
    settle();
    checkOutput("scan_busy_hold", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();
    applyStimulus(32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput($sformatf("scan_shift8_%0d", i), {Shift_1_En_O, Shift_8_En_O}, 2'b01);
      nextCycle();
    end
    applyStimulus(32'h00000100, 1'b1, 1'b0);
    settle();
    checkOutput("scan_stop_on_pic_code", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    checkOutput("pic_done_not_yet", Picture_Done_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("pic1_done_pulse", Picture_Done_O, 1'b1);
    checkOutput("pic1_count", Picture_Count_O, 16'd1);
    checkOutput("pic_end_no_shift", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();

    // ---- picture 2: fast header, one slice, sequence end ----
    applyStimulus(32'h00000103, 1'b0, 1'b0);
    headerFast("pic2");
    settle();
    checkOutput("pic2_slice_pulse", Slice_Start_O, 1'b1);
    checkOutput("pic2_count_held", Picture_Count_O, 16'd1);
    nextCycle();
    Slice_Done_I = 1'b1;
    applyStimulus(32'h000001B7, 1'b0, 1'b0);
    nextCycle();
    Slice_Done_I = 1'b0;
    settle();
    checkOutput("seq_end_scan_no_shift", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();
    settle();
    checkOutput("pic2_done_pulse", Picture_Done_O, 1'b1);
    checkOutput("pic2_count", Picture_Count_O, 16'd2);
    checkOutput("seq_end_not_yet", Seq_End_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("seq_end_set", Seq_End_O, 1'b1);
    checkOutput("seq_end_no_hdr", Start_Header_Decode_O, 1'b0);
    checkOutput("pic2_done_single", Picture_Done_O, 1'b0);
    nextCycle();
    settle();
    checkOutput("seq_end_stays_idle", Start_Header_Decode_O, 1'b0);
    nextCycle();

    // ---- Stop and Slice_Done in the same cycle ----
    Start_Decode_I = 1'b1;
    settle();
    checkOutput("seq_end_sticky", Seq_End_O, 1'b1);
    nextCycle();
    Start_Decode_I = 1'b0;
    applyStimulus(32'h00000101, 1'b0, 1'b0);
    headerFast("stop");
    settle();
    checkOutput("seq_end_cleared", Seq_End_O, 1'b0);
    checkOutput("stop_slice_pulse", Slice_Start_O, 1'b1);
    nextCycle();
    Slice_Done_I  = 1'b1;
    Stop_Decode_I = 1'b1;
    applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0);
    nextCycle();
    Slice_Done_I  = 1'b0;
    Stop_Decode_I = 1'b0;
    settle();
    checkOutput("stop_beats_done_no_scan", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    checkOutput("stop_no_hdr", Start_Header_Decode_O, 1'b0);
    checkOutput("stop_count_retained", Picture_Count_O, 16'd2);
    nextCycle();
    settle();
    checkOutput("stop_idle_no_shift", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();

    // ---- watchdog expiry in SLICE_WAIT ----
    Start_Decode_I = 1'b1;
    nextCycle();
    Start_Decode_I = 1'b0;
    applyStimulus(32'h00000101, 1'b0, 1'b0);
    headerFast("wd");
    settle();
    checkOutput("wd_slice_pulse", Slice_Start_O, 1'b1);
    errSeen = 0;
    for (int k = 1; k < 16; k++) begin
      nextCycle();
      settle();
      errSeen += int'(Error_O);
    end
    checkOutput("wd_no_early_error", errSeen, 0);
    nextCycle();
    settle();
    checkOutput("wd_error_at_16", Error_O, 1'b1);
    nextCycle();
    Slc_Shift_8_En_I = 1'b1;
    Slc_Shift_1_En_I = 1'b1;
    settle();
    checkOutput("wd_slc_blocked", {Shift_1_En_O, Shift_8_En_O}, 2'b00);
    nextCycle();
    Slc_Shift_8_En_I = 1'b0;
    Slc_Shift_1_En_I = 1'b0;

    // ---- reset while SCAN is driving Shift_8_En_O ----
    Start_Decode_I = 1'b1;
    settle();
    checkOutput("wd_error_sticky", Error_O, 1'b1);
    nextCycle();
    Start_Decode_I = 1'b0;
    applyStimulus(32'h00000000, 1'b1, 1'b0);
    headerFast("rst");
    settle();
    checkOutput("rst_scan_shift8", {Shift_1_En_O, Shift_8_En_O}, 2'b01);
    checkOutput("error_cleared_by_start", Error_O, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {Start_Header_Decode_O, Slice_Start_O, Shift_1_En_O, Shift_8_En_O,
                Picture_Done_O, Seq_End_O, Error_O, Picture_Count_O}, 32'h0);
    nextCycle();
    nextCycle();
    resetn = 1'b1;
    settle();
    checkOutput("post_reset_idle_0", {Start_Header_Decode_O, Slice_Start_O, Shift_1_En_O, Shift_8_En_O,
                Picture_Done_O}, 5'b0);
    nextCycle();
    settle();
    checkOutput("post_reset_idle_1", {Start_Header_Decode_O, Slice_Start_O, Shift_1_En_O, Shift_8_En_O,
                Picture_Done_O}, 5'b0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
